// File: rtl/dmem_if.sv
// Request/response bus between the memory-stage initiator and the data-memory responder.
// Both channels: a beat transfers on a rising edge where valid && ready; the sender keeps its payload stable until then.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a programmable access latency, serving one
// load/store at a time over valid/ready request and response channels.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_if.slave      bus,
  output logic [1:0] dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                  state, state_d;
  logic [3:0]              cnt, cnt_d;
  logic                    accept, enter_resp;
  logic                    in_err;
  logic [ADDR_WIDTH-1:0]   in_idx;
  logic                    we_q, err_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    sel_we, sel_err;
  logic [ADDR_WIDTH-1:0]   sel_idx;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [0:(2**ADDR_WIDTH)-1];

  assign in_err = (bus.req_addr[1:0] != 2'b00) || (|bus.req_addr[31:ADDR_WIDTH+2]);
  assign in_idx = bus.req_addr[ADDR_WIDTH+1:2];
  assign accept = bus.req_valid && (state == IDLE);

  // With LATENCY=1 the response is built on the accept edge, before the latches hold the request.
  assign sel_we  = (state == IDLE) ? bus.req_we : we_q;
  assign sel_err = (state == IDLE) ? in_err     : err_q;
  assign sel_idx = (state == IDLE) ? in_idx     : idx_q;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state != RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q  <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      we_q  <= bus.req_we;
      err_q <= in_err;
      idx_q <= in_idx;
    end
  end

  // Load data is captured once on entry to RESP so it stays stable under back-pressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (enter_resp) begin
      rdata_q <= (!sel_we && !sel_err) ? mem[sel_idx] : 32'd0;
    end else if ((state == RESP) && bus.rsp_ready) begin
      rdata_q <= 32'd0;
    end
  end

  // Stores commit on the accept edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !in_err) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) mem[in_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_err   = (state == RESP) && err_q;
  assign bus.rsp_rdata = rdata_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for function, stall and
// reset cases, and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_if bus2 ();
  dmem_if bus1 ();
  logic [1:0] st2, st1;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2)
  );
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(st1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  int          acc_c [3];
  int          rsp_c [3];
  logic [31:0] rsp_d [3];
  int          nr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full LATENCY=2 transaction; lat counts cycles from the accept cycle to the first rsp_valid cycle.
  task automatic xact2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rdata, output logic err,
                       output int lat);
    int n;
    bus2.req_we    = we;
    bus2.req_addr  = addr;
    bus2.req_wdata = wdata;
    bus2.req_be    = be;
    bus2.req_valid = 1'b1;
    n = 0;
    while (!bus2.req_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus2.req_valid = 1'b0;
    bus2.req_we    = 1'bx;
    bus2.req_addr  = 'x;
    bus2.req_wdata = 'x;
    bus2.req_be    = 'x;
    lat = 1;
    while (!bus2.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    rdata = bus2.rsp_rdata;
    err   = bus2.rsp_err;
    tick();
  endtask

  // Back-to-back requests to 0x0/0x4/0x8 on the LATENCY=1 instance with valid held high.
  task automatic run1(input logic we);
    int k;
    k  = 0;
    nr = 0;
    bus1.req_we    = we;
    bus1.req_addr  = 32'h0;
    bus1.req_wdata = 32'hA000_0000;
    bus1.req_be    = 4'hF;
    bus1.req_valid = 1'b1;
    for (int c = 0; c < 20 && nr < 3; c++) begin
      if (bus1.rsp_valid) begin
        rsp_d[nr] = bus1.rsp_rdata;
        rsp_c[nr] = c;
        nr++;
      end
      if (bus1.req_valid && bus1.req_ready) begin
        acc_c[k] = c;
        k++;
      end
      tick();
      if (k < 3) begin
        bus1.req_addr  = 32'(k * 4);
        bus1.req_wdata = 32'hA000_0000 + 32'(k);
      end else begin
        bus1.req_valid = 1'b0;
      end
    end
    bus1.req_valid = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          n;

  initial begin
    rst = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'h0;
    bus2.req_wdata = 32'h0; bus2.req_be = 4'h0; bus2.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 32'h0;
    bus1.req_wdata = 32'h0; bus1.req_be = 4'h0; bus1.rsp_ready = 1'b1;
    #1;
    check("rst_req_ready", 32'(bus2.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus2.rsp_rdata, 32'd0);
    check("rst_rsp_err",   32'(bus2.rsp_err), 32'd0);
    check("rst_state",     32'(st2), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Store then load, latency measured on both
    xact2(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("st10_lat",   32'(lat), 32'd2);
    check("st10_rdata", rd, 32'd0);
    check("st10_err",   32'(er), 32'd0);
    xact2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_lat",   32'(lat), 32'd2);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);
    check("ld10_err",   32'(er), 32'd0);
    check("idle_after_hs", 32'(bus2.req_ready), 32'd1);

    // Byte-lane merge
    xact2(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
    xact2(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    check("st20_be_err", 32'(er), 32'd0);
    xact2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("ld20_merge", rd, 32'h11BB_33DD);

    // be=0000 is a no-op store
    xact2(1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    xact2(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be0_keep", rd, 32'hDEAD_BEEF);

    // Error cases
    xact2(1'b1, 32'h0, 32'h1234_5678, 4'hF, rd, er, lat);
    xact2(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    check("mis_err",   32'(er), 32'd1);
    check("mis_rdata", rd, 32'd0);
    xact2(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("oor_err",   32'(er), 32'd1);
    check("oor_rdata", rd, 32'd0);
    xact2(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    check("oor_nowrite", rd, 32'h1234_5678);
    check("oor_ok_err",  32'(er), 32'd0);

    // Back-pressure: hold rsp_ready low for 5 cycles with a stray request pending
    bus2.rsp_ready = 1'b0;
    bus2.req_we = 1'b0; bus2.req_addr = 32'h20; bus2.req_be = 4'h0; bus2.req_valid = 1'b1;
    tick();
    bus2.req_we = 1'b1; bus2.req_wdata = 32'hFFFF_FFFF; bus2.req_be = 4'hF;
    n = 1;
    while (!bus2.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("stall_lat", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(bus2.rsp_valid), 32'd1);
      check("stall_rdata", bus2.rsp_rdata, 32'h11BB_33DD);
      check("stall_err",   32'(bus2.rsp_err), 32'd0);
      check("stall_ready", 32'(bus2.req_ready), 32'd0);
      tick();
    end
    bus2.req_valid = 1'b0;
    bus2.rsp_ready = 1'b1;
    tick();
    check("stall_hs_valid", 32'(bus2.rsp_valid), 32'd0);
    check("stall_hs_ready", 32'(bus2.req_ready), 32'd1);
    check("stall_hs_rdata", bus2.rsp_rdata, 32'd0);
    xact2(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("stall_ignored_store", rd, 32'h11BB_33DD);

    // LATENCY=1 throughput: stores then loads, valid and rsp_ready held high
    run1(1'b1);
    check("l1_st_count", 32'(nr), 32'd3);
    for (int i = 0; i < 3; i++) check("l1_st_rdata", rsp_d[i], 32'd0);
    for (int i = 0; i < 3; i++) exp_q.push_back(32'hA000_0000 + 32'(i));
    tick();
    run1(1'b0);
    check("l1_ld_count", 32'(nr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("l1_acc_cycle", 32'(acc_c[i]), 32'(2 * i));
      check("l1_rsp_cycle", 32'(rsp_c[i]), 32'(2 * i + 1));
      check("l1_ld_rdata",  rsp_d[i], exp_q.pop_front());
    end

    // Asynchronous reset in WAIT of a store
    bus2.req_we = 1'b1; bus2.req_addr = 32'h8; bus2.req_wdata = 32'h5;
    bus2.req_be = 4'hF; bus2.req_valid = 1'b1;
    tick();
    bus2.req_valid = 1'b0;
    check("wait_state", 32'(st2), 32'd1);
    check("wait_ready", 32'(bus2.req_ready), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("arst_wait_ready", 32'(bus2.req_ready), 32'd1);
    check("arst_wait_valid", 32'(bus2.rsp_valid), 32'd0);
    check("arst_wait_state", 32'(st2), 32'd0);
    tick();
    rst = 1'b0;
    xact2(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
    check("arst_store_kept", rd, 32'h5);

    // Asynchronous reset in a stalled RESP
    bus2.rsp_ready = 1'b0;
    bus2.req_we = 1'b0; bus2.req_addr = 32'h10; bus2.req_valid = 1'b1;
    tick();
    bus2.req_valid = 1'b0;
    tick();
    check("resp_valid_pre", 32'(bus2.rsp_valid), 32'd1);
    check("resp_rdata_pre", bus2.rsp_rdata, 32'hDEAD_BEEF);
    #3;
    rst = 1'b1;
    #1;
    check("arst_resp_valid", 32'(bus2.rsp_valid), 32'd0);
    check("arst_resp_rdata", bus2.rsp_rdata, 32'd0);
    check("arst_resp_err",   32'(bus2.rsp_err), 32'd0);
    check("arst_resp_ready", 32'(bus2.req_ready), 32'd1);
    tick();
    rst = 1'b0;
    bus2.rsp_ready = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipeline MEMORY stage.
- Accepts word load/store requests from the memory-stage initiator over a valid/ready request channel.
- Applies a programmable access latency and returns read data or an error over a valid/ready response channel.
- Holds the word-addressed data array and replaces the ideal zero-wait memory for timing-realistic simulation.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles from request acceptance to first cycle of rsp_valid; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i selects byte lane i.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator consumes the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Reset: asynchronous. Sets FSM to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready=1 only in IDLE.
- Accept: req_valid && req_ready at a rising edge. Latch we/addr/wdata/be.
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with counter=LATENCY-1.
- WAIT: decrement the counter each edge. At counter==1, go to RESP on that edge. rsp_valid goes high exactly LATENCY cycles after the accept edge.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are stable while rsp_valid=1 && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE and drop rsp_valid and rsp_err. rsp_rdata returns to 0.
  - A new request cannot be accepted in the same cycle as the response handshake. Peak throughput is one request per LATENCY+1 cycles when rsp_ready is held high.
- Error check, evaluated on the latched request:
  - err if addr[1:0] != 0.
  - err if any bit of addr[31:ADDR_WIDTH+2] is set.
  - On err: no array write, rsp_rdata=0, rsp_err=1.
- Store, no err: array is written on the accept edge, only byte lanes with be[i]=1. Lanes with be[i]=0 keep their old value. be=0000 is a legal no-op with rsp_err=0. Store response: rsp_rdata=0.
- Load, no err: rsp_rdata is array[addr[ADDR_WIDTH+1:2]] sampled when entering RESP. It therefore reflects any store accepted earlier.
- Request signals are ignored outside IDLE; req_valid held high during WAIT/RESP has no effect.
- Reset during WAIT or RESP:
  - The pending response is discarded and the FSM returns to IDLE.
  - A store accepted before reset remains committed.
- X on req_* while req_valid=0 must not affect state.

Test Plan:
- LATENCY=2, load from 0x10 after store of 0xDEADBEEF, be=1111 → rsp_valid rises exactly 2 cycles after the load accept; rsp_rdata=0xDEADBEEF; rsp_err=0.
- Store 0x11223344 to 0x20 with be=1111, then store 0xAABBCCDD with be=0101, then load 0x20 → rsp_rdata=0x11BB33DD.
- Load from 0x22 (misaligned), then store to 0x1000 (out of range for ADDR_WIDTH=10) → both give rsp_err=1 and rsp_rdata=0; a later load of 0x1000 & 0xFFC is unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err are stable; req_ready=0 throughout; raising rsp_ready gives one handshake, then req_ready=1 the next cycle.
- LATENCY=1 with req_valid and rsp_ready tied high, loads to 0x0,0x4,0x8 → accepts every 2 cycles; responses arrive in order with correct data.
- Assert rst asynchronously mid-WAIT of a store of 0x5 to 0x8 → outputs return to reset values immediately without a clock edge; a later load of 0x8 returns 0x5.
